// File: rtl/qsys_lab2_nios2_gen2_0_cpu_ocimem_arb.sv
// Debug monitor RAM with JTAG/CPU arbitration.
// JTAG commands are queued as pending flags and win over waiting CPU accesses.
module qsys_lab2_nios2_gen2_0_cpu_ocimem_arb #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic              debugaccess,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              jtag_rd_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    JWR      = 3'd1,
    JRD      = 3'd2,
    JRD_WAIT = 3'd3,
    CPU_RD   = 3'd4,
    CPU_WAIT = 3'd5,
    CPU_DONE = 3'd6
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] MonAReg;
  logic              jrd_pend;
  logic              jwr_pend;
  logic [31:0]       jwr_data;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wd;
  logic              jwr_done;
  logic              jrd_done;
  logic              rd_load;

  logic unused_jdo;
  assign unused_jdo = ^jdo[37:36];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM next state: JTAG write, JTAG read, CPU read, CPU write
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (jwr_pend)                state_nx = JWR;
        else if (jrd_pend)           state_nx = JRD;
        else if (chipselect && read) state_nx = CPU_RD;
        else if (chipselect && write) state_nx = CPU_DONE;
      end
      JWR:      state_nx = IDLE;
      JRD:      state_nx = JRD_WAIT;
      JRD_WAIT: state_nx = IDLE;
      CPU_RD:   state_nx = CPU_WAIT;
      CPU_WAIT: state_nx = CPU_DONE;
      CPU_DONE: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // FSM outputs: RAM port mux and completion strobes
  always_comb begin
    ram_addr = address;
    ram_we   = 1'b0;
    ram_be   = byteenable;
    ram_wd   = writedata;
    jwr_done = 1'b0;
    jrd_done = 1'b0;
    rd_load  = 1'b0;
    case (state)
      IDLE: begin
        if (!jwr_pend && !jrd_pend && chipselect &&
            !read && write && debugaccess)
          ram_we = 1'b1;
      end
      JWR: begin
        ram_addr = MonAReg;
        ram_we   = 1'b1;
        ram_be   = 4'hF;
        ram_wd   = jwr_data;
        jwr_done = 1'b1;
      end
      JRD: ram_addr = MonAReg;
      JRD_WAIT: begin
        ram_addr = MonAReg;
        jrd_done = 1'b1;
      end
      CPU_WAIT: rd_load = 1'b1;
      default: ;
    endcase
  end

  assign waitrequest = chipselect & (read | write) &
                       (state != CPU_DONE);

  // JTAG command capture; a new strobe overrides completion clears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonAReg  <= '0;
      jrd_pend <= 1'b0;
      jwr_pend <= 1'b0;
      jwr_data <= '0;
    end else begin
      if (take_action_ocimem_a)
        MonAReg <= jdo[ADDR_W-1:0];
      else if (jwr_done || jrd_done)
        MonAReg <= MonAReg + 1'b1;

      if ((take_action_ocimem_a && jdo[35]) || take_no_action_ocimem_a)
        jrd_pend <= 1'b1;
      else if (jrd_done)
        jrd_pend <= 1'b0;

      if (take_action_ocimem_b) begin
        jwr_pend <= 1'b1;
        jwr_data <= jdo[34:3];
      end else if (jwr_done) begin
        jwr_pend <= 1'b0;
      end
    end
  end

  // Registered read data returned to JTAG and CPU
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonDReg      <= '0;
      jtag_rd_done <= 1'b0;
      readdata     <= '0;
    end else begin
      jtag_rd_done <= jrd_done;
      if (jrd_done) MonDReg  <= ram_q;
      if (rd_load)  readdata <= ram_q;
    end
  end

  // Single-port RAM, byte-lane writes, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
    end
    ram_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_qsys_lab2_nios2_gen2_0_cpu_ocimem_arb.sv
// Directed bench for the debug monitor RAM arbiter.
// Linear stimulus with immediate-assertion checks.
module tb_qsys_lab2_nios2_gen2_0_cpu_ocimem_arb;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [7:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic        debugaccess;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        jtag_rd_done;

  int n_cmp;
  int n_err;

  qsys_lab2_nios2_gen2_0_cpu_ocimem_arb #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .address                 (address),
    .chipselect              (chipselect),
    .read                    (read),
    .write                   (write),
    .debugaccess             (debugaccess),
    .byteenable              (byteenable),
    .writedata               (writedata),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .jtag_rd_done            (jtag_rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic [7:0] a, input logic rd);
    jdo = '0;
    jdo[7:0] = a;
    jdo[35] = rd;
    take_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_tna();
    take_no_action_ocimem_a = 1'b1;
    cyc();
    take_no_action_ocimem_a = 1'b0;
  endtask

  // JTAG write spaced so the next strobe sees an idle FSM
  task automatic jwrite(input logic [31:0] d);
    jtag_b(d);
    cyc();
    cyc();
  endtask

  // Strobe in T, then MonDReg sampled in T+4
  task automatic jread_chk(input logic [7:0] a, input logic [31:0] exp,
                           input string tag);
    jtag_a(a, 1'b1);
    cyc(); cyc(); cyc();
    @(negedge clk);
    check({tag, "_mond"}, MonDReg, exp);
    check({tag, "_done"}, {31'd0, jtag_rd_done}, 32'd1);
    cyc();
  endtask

  task automatic tna_chk(input logic [31:0] exp, input string tag);
    jtag_tna();
    cyc(); cyc(); cyc();
    @(negedge clk);
    check({tag, "_mond"}, MonDReg, exp);
    check({tag, "_done"}, {31'd0, jtag_rd_done}, 32'd1);
    cyc();
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic dbg,
                           input string tag);
    address = a;
    writedata = d;
    byteenable = be;
    debugaccess = dbg;
    chipselect = 1'b1;
    write = 1'b1;
    @(negedge clk);
    check({tag, "_wait_c"}, {31'd0, waitrequest}, 32'd1);
    cyc();
    @(negedge clk);
    check({tag, "_wait_c1"}, {31'd0, waitrequest}, 32'd0);
    chipselect = 1'b0;
    write = 1'b0;
    debugaccess = 1'b0;
    cyc();
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp,
                          input int lat, input string tag);
    address = a;
    chipselect = 1'b1;
    read = 1'b1;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_wait_hi"}, {31'd0, waitrequest}, 32'd1);
      cyc();
    end
    @(negedge clk);
    check({tag, "_wait_lo"}, {31'd0, waitrequest}, 32'd0);
    check({tag, "_data"}, readdata, exp);
    chipselect = 1'b0;
    read = 1'b0;
    cyc();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    address = '0;
    chipselect = 1'b0;
    read = 1'b0;
    write = 1'b0;
    debugaccess = 1'b0;
    byteenable = '0;
    writedata = '0;

    repeat (3) cyc();
    @(negedge clk);
    check("rst_readdata", readdata, 32'd0);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_rd_done", {31'd0, jtag_rd_done}, 32'd0);
    check("rst_wait", {31'd0, waitrequest}, 32'd0);
    check("rst_areg", {24'd0, dut.MonAReg}, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // address load then write
    jtag_a(8'h10, 1'b0);
    jwrite(32'hDEADBEEF);
    @(negedge clk);
    check("wr_areg", {24'd0, dut.MonAReg}, 32'h11);
    check("wr_pend_clr", {31'd0, dut.jwr_pend}, 32'd0);
    cyc();
    jwrite(32'hCAFEF00D);

    // JTAG read latency: nothing by T+3, data and pulse in T+4
    jtag_a(8'h10, 1'b1);
    cyc(); cyc();
    @(negedge clk);
    check("jrd_t3_done", {31'd0, jtag_rd_done}, 32'd0);
    check("jrd_t3_mond", MonDReg, 32'd0);
    cyc();
    @(negedge clk);
    check("jrd_t4_mond", MonDReg, 32'hDEADBEEF);
    check("jrd_t4_done", {31'd0, jtag_rd_done}, 32'd1);
    cyc();
    @(negedge clk);
    check("jrd_t5_done", {31'd0, jtag_rd_done}, 32'd0);
    check("jrd_areg", {24'd0, dut.MonAReg}, 32'h11);
    cyc();
    tna_chk(32'hCAFEF00D, "tna_11");

    // address wrap
    jtag_a(8'hFF, 1'b0);
    jwrite(32'h1);
    jwrite(32'h2);
    @(negedge clk);
    check("wrap_areg", {24'd0, dut.MonAReg}, 32'h01);
    cyc();
    jread_chk(8'hFF, 32'h1, "wrap_ff");
    tna_chk(32'h2, "wrap_00");

    // CPU byte-lane write, then discarded non-debug write
    jtag_a(8'h20, 1'b0);
    jwrite(32'hAAAAAAAA);
    cpu_write(8'h20, 32'h12345678, 4'b0011, 1'b1, "cwr_dbg");
    cpu_read(8'h20, 32'hAAAA5678, 3, "crd_be");
    cpu_write(8'h20, 32'hFFFFFFFF, 4'hF, 1'b0, "cwr_nodbg");
    cpu_read(8'h20, 32'hAAAA5678, 3, "crd_nodbg");

    // CPU read while a JTAG write is pending: write goes first
    jtag_a(8'h30, 1'b0);
    jtag_b(32'h0BADF00D);
    cpu_read(8'h30, 32'h0BADF00D, 5, "contend");
    @(negedge clk);
    check("contend_areg", {24'd0, dut.MonAReg}, 32'h31);
    cyc();

    // reset during JRD_WAIT
    jtag_a(8'h10, 1'b1);
    cyc(); cyc();
    @(negedge clk);
    check("mid_state", {29'd0, dut.state}, 32'd3);
    check("mid_jrd_pend", {31'd0, dut.jrd_pend}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mrst_readdata", readdata, 32'd0);
    check("mrst_mondreg", MonDReg, 32'd0);
    check("mrst_rd_done", {31'd0, jtag_rd_done}, 32'd0);
    check("mrst_wait", {31'd0, waitrequest}, 32'd0);
    check("mrst_state", {29'd0, dut.state}, 32'd0);
    check("mrst_jrd_pend", {31'd0, dut.jrd_pend}, 32'd0);
    check("mrst_jwr_pend", {31'd0, dut.jwr_pend}, 32'd0);
    check("mrst_areg", {24'd0, dut.MonAReg}, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    jread_chk(8'h10, 32'hDEADBEEF, "post_rst_jrd");
    cpu_read(8'h20, 32'hAAAA5678, 3, "post_rst_crd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
